audio_pitch_detector: RTL and testbench
=======================================

Name: audio_pitch_detector

Overview:
Receive-side companion to the on-chip square-wave tone generator. It samples a 1-bit audio square wave, measures the half-period in clk cycles, normalises it to an octave plus base period, and classifies it against the 12-entry note table. Used for loopback self-test and for decoding an external 1-bit tone input into a (note, octave) pair.

Parameters:
CNT_W, 16, width of the half-period counter; the silence timeout is 2^CNT_W-1 cycles. Must be >= 10.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
audio_in  input  1  asynchronous 1-bit square wave
note_valid  output  1  one-cycle pulse; note/octave/half_period are updated this cycle
note  output  4  note index 0..11; 0 is the lowest pitch (longest period)
octave  output  3  octave index 0..7 (number of normalisation halvings)
half_period  output  CNT_W  last classified raw half-period in cycles
silent  output  1  level; no edge seen for 2^CNT_W-1 cycles
out_of_range  output  1  level; the last classification failed

Behaviour:
- Reset values: all outputs 0, except silent=1. State is IDLE. Counter is 0. Sync flops are 0.
- Input path: 2-flop synchroniser, then a prev register. An edge is detected when sync != prev. Both edges count.
- IDLE: the first edge clears silent, loads cnt=1, and moves to MEASURE. Nothing is classified from this edge.
- MEASURE: cnt increments every cycle.
  - On an edge: capture H=cnt, reload cnt=1, stay in MEASURE. If the classifier is idle, start it with H; if it is busy, drop H.
  - If cnt reaches 2^CNT_W-1 with no edge: set silent=1, go to IDLE. The classifier finishes any job already in flight.
- Classifier, a separate sub-FSM (C_IDLE, C_NORM, C_CLASS):
  - C_NORM: each cycle, if h>=528 then h<=h>>1 and s<=s+1. Otherwise go to C_CLASS. s is 4 bits and saturates at 15.
  - C_CLASS (one cycle):
    - If s>7 or h<264: out_of_range=1, no note_valid.
    - Otherwise: note from thresholds on h: >=497→0, >=469→1, >=444→2, >=419→3, >=395→4, >=373→5, >=352→6, >=333→7, >=314→8, >=296→9, >=279→10, else 11. Set octave=s, half_period=H, out_of_range=0, and pulse note_valid.
- Latency: note_valid is asserted s+2 cycles after the edge-detect cycle (s=0: 2 cycles).
- note, octave and half_period hold until the next successful classification.
- Simultaneous events:
  - Edge in the same cycle cnt saturates: the edge wins. cnt=1, silent stays 0.
  - Timeout while a job is in C_NORM: silent=1, and the job still completes.
- rst_n low at any point aborts measurement and classification, returning all state to reset values on the next clk.

Optional Feature:
PITCH_AGREE_EN
- Defined: a successful classification is held as a candidate. note_valid pulses only when the current result has the same note and octave as the immediately preceding successful result. A mismatch replaces the candidate, with no pulse.
- Any out-of-range result, entry to IDLE, or reset clears the candidate.
- Outputs update only on the pulse.
- Undefined: every successful classification pulses, as in Behaviour.

Test Plan:
- Toggle audio_in every 512 cycles → after the 2nd edge, note_valid at s+2=2 cycles with note=0, octave=0, half_period=512. Repeats every edge.
- Toggle every 4096 cycles → s=3, note_valid 5 cycles after edge detect; note=0, octave=3, half_period=4096.
- Toggle every 608 cycles → h=304 after one halving; note=9, octave=1. Then switch to 542 → h=271, note=11, octave=1.
- Toggle every 200 cycles → out_of_range=1, note_valid never pulses. Then switch to 512 → out_of_range=0, note=0.
- Stop toggling after a valid tone → silent=1 exactly 65535 cycles after the last edge counter reload (CNT_W=16). The next edge clears silent and produces no note_valid; the following edge does.
- Assert rst_n mid-measurement, then toggle at 362 → no pulse from the pre-reset period. After two post-reset edges, note=6, octave=0. With PITCH_AGREE_EN, the first pulse comes on the 3rd edge.

Source files
------------

// File: rtl/audio_pitch_detector.sv
// audio_pitch_detector: measures the half-period of a 1-bit square wave,
// normalises it to (octave, base half-period) and classifies it against the
// 12-entry note table.
// Optional build macro PITCH_AGREE_EN: publish a note only when two
// consecutive successful classifications agree on note and octave.
module audio_pitch_detector #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             audio_in,
    output logic             note_valid,
    output logic [3:0]       note,
    output logic [2:0]       octave,
    output logic [CNT_W-1:0] half_period,
    output logic             silent,
    output logic             out_of_range
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] NORM_LIM = CNT_W'(528);
    localparam logic [CNT_W-1:0] MIN_H    = CNT_W'(264);
    // Lower bounds of notes 0..10 on the normalised half-period; below the last is note 11
    localparam logic [9:0] NOTE_TH [11] = '{10'd497, 10'd469, 10'd444, 10'd419, 10'd395,
                                            10'd373, 10'd352, 10'd333, 10'd314, 10'd296,
                                            10'd279};

    typedef enum logic {M_IDLE, M_MEASURE} mstate_t;
    typedef enum logic [1:0] {C_IDLE, C_NORM, C_CLASS} cstate_t;

    mstate_t          mstate;
    cstate_t          cstate;
    logic             sync1, sync2, prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] hcap;
    logic [3:0]       s;
    logic             toggle;
    logic             timeout;
    logic             start;
    logic [3:0]       note_lut;

`ifdef PITCH_AGREE_EN
    logic             cand_valid;
    logic [3:0]       cand_note;
    logic [2:0]       cand_oct;
`endif

    // Edge detect, timeout/start qualifiers and note lookup on the normalised half-period
    always_comb begin
        toggle   = (sync2 != prev);
        timeout  = (mstate == M_MEASURE) && !toggle && (cnt == CNT_MAX);
        start    = (mstate == M_MEASURE) && toggle && (cstate == C_IDLE);
        note_lut = 4'd0;
        for (int unsigned i = 0; i < 11; i++) begin
            if (h < CNT_W'(NOTE_TH[i])) note_lut = note_lut + 4'd1;
        end
    end

    // Input synchroniser and half-period measurement FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            cnt    <= '0;
            silent <= 1'b1;
            mstate <= M_IDLE;
        end else begin
            sync1 <= audio_in;
            sync2 <= sync1;
            prev  <= sync2;
            case (mstate)
                M_IDLE: begin
                    if (toggle) begin
                        silent <= 1'b0;
                        cnt    <= CNT_ONE;
                        mstate <= M_MEASURE;
                    end
                end
                M_MEASURE: begin
                    // An edge on the saturation cycle takes priority over the timeout
                    if (toggle) begin
                        cnt <= CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        silent <= 1'b1;
                        cnt    <= '0;
                        mstate <= M_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: mstate <= M_IDLE;
            endcase
        end
    end

    // Classifier: normalise by halving, then classify and publish registered results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cstate       <= C_IDLE;
            h            <= '0;
            hcap         <= '0;
            s            <= '0;
            note_valid   <= 1'b0;
            note         <= '0;
            octave       <= '0;
            half_period  <= '0;
            out_of_range <= 1'b0;
`ifdef PITCH_AGREE_EN
            cand_valid   <= 1'b0;
            cand_note    <= '0;
            cand_oct     <= '0;
`endif
        end else begin
            note_valid <= 1'b0;
            case (cstate)
                C_IDLE: begin
                    if (start) begin
                        h      <= cnt;
                        hcap   <= cnt;
                        s      <= '0;
                        cstate <= C_NORM;
                    end
                end
                C_NORM: begin
                    if (h >= NORM_LIM) begin
                        h <= h >> 1;
                        s <= (s == 4'hF) ? s : s + 4'd1;
                    end else begin
                        cstate <= C_CLASS;
                    end
                end
                C_CLASS: begin
                    cstate <= C_IDLE;
                    if (s > 4'd7 || h < MIN_H) begin
                        out_of_range <= 1'b1;
`ifdef PITCH_AGREE_EN
                        cand_valid   <= 1'b0;
`endif
                    end else begin
                        out_of_range <= 1'b0;
`ifdef PITCH_AGREE_EN
                        if (cand_valid && cand_note == note_lut && cand_oct == s[2:0]) begin
                            note_valid  <= 1'b1;
                            note        <= note_lut;
                            octave      <= s[2:0];
                            half_period <= hcap;
                        end
                        cand_valid <= 1'b1;
                        cand_note  <= note_lut;
                        cand_oct   <= s[2:0];
`else
                        note_valid  <= 1'b1;
                        note        <= note_lut;
                        octave      <= s[2:0];
                        half_period <= hcap;
`endif
                    end
                end
                default: cstate <= C_IDLE;
            endcase
`ifdef PITCH_AGREE_EN
            // Going silent forgets any pending candidate
            if (timeout) cand_valid <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_audio_pitch_detector.sv
// Self-checking bench for audio_pitch_detector (CNT_W=13 to keep the timeout short).
module tb_audio_pitch_detector;

    localparam int CNT_W   = 13;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PITCH_AGREE_EN
    localparam bit AGREE = 1'b1;
`else
    localparam bit AGREE = 1'b0;
`endif
    localparam int TH [11] = '{497, 469, 444, 419, 395, 373, 352, 333, 314, 296, 279};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             audio_in = 1'b0;
    logic             note_valid;
    logic [3:0]       note;
    logic [2:0]       octave;
    logic [CNT_W-1:0] half_period;
    logic             silent;
    logic             out_of_range;

    typedef struct {
        int note;
        int oct;
        int hp;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   meas = 1'b0;
    bit   cand_v = 1'b0;
    int   cand_note = 0;
    int   cand_oct = 0;
    int   last_drive = 0;

    audio_pitch_detector #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_in     (audio_in),
        .note_valid   (note_valid),
        .note         (note),
        .octave       (octave),
        .half_period  (half_period),
        .silent       (silent),
        .out_of_range (out_of_range)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic classify(input int n, output bit ok, output int nt, output int s);
        int hh;
        hh = n;
        s  = 0;
        while (hh >= 528) begin
            hh = hh >> 1;
            s++;
        end
        ok = (s <= 7) && (hh >= 264);
        nt = 0;
        for (int i = 0; i < 11; i++) if (hh < TH[i]) nt++;
    endtask

    // Predict the outcome of an edge driven at the current cycle
    task automatic predict();
        int  gap, nt, s;
        bit  ok;
        exp_t e;
        gap = cyc - last_drive;
        if (!meas || gap > CNT_MAX) begin
            meas   = 1'b1;
            cand_v = 1'b0;
        end else begin
            classify(gap, ok, nt, s);
            if (!ok) begin
                cand_v = 1'b0;
            end else begin
                if (!AGREE || (cand_v && cand_note == nt && cand_oct == s)) begin
                    e.note = nt;
                    e.oct  = s;
                    e.hp   = gap;
                    e.due  = cyc + 5 + s;
                    sb.push_back(e);
                end
                cand_v    = 1'b1;
                cand_note = nt;
                cand_oct  = s;
            end
        end
        last_drive = cyc;
    endtask

    task automatic tone(input int n, input int edges);
        for (int k = 0; k < edges; k++) begin
            repeat (n) @(negedge clk);
            audio_in = ~audio_in;
            predict();
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard: every pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && note_valid) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", 1, 0);
            end else begin
                got = sb.pop_front();
                check("note", int'(note), got.note);
                check("octave", int'(octave), got.oct);
                check("half_period", int'(half_period), got.hp);
                check("latency", cyc, got.due);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        audio_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_note_valid", int'(note_valid), 0);
        check("rst_note", int'(note), 0);
        check("rst_octave", int'(octave), 0);
        check("rst_half_period", int'(half_period), 0);
        check("rst_silent", int'(silent), 1);
        check("rst_out_of_range", int'(out_of_range), 0);

        tone(512, 4);
        tone(4096, 3);
        tone(608, 3);
        tone(542, 3);
        tone(200, 3);
        repeat (20) @(negedge clk);
        check("oor_set", int'(out_of_range), 1);
        check("not_silent", int'(silent), 0);
        tone(512, 2);
        repeat (20) @(negedge clk);
        check("oor_clear", int'(out_of_range), 0);
        check("note_after_oor", int'(note), 0);

        wait_until(last_drive + 3 + CNT_MAX - 1);
        check("silent_before_timeout", int'(silent), 0);
        @(negedge clk);
        check("silent_at_timeout", int'(silent), 1);

        tone(512, 1);
        repeat (5) @(negedge clk);
        check("silent_cleared", int'(silent), 0);
        tone(512, 1);
        tone(CNT_MAX, 1);
        repeat (20) @(negedge clk);
        check("silent_edge_at_saturation", int'(silent), 0);

        repeat (100) @(negedge clk);
        rst_n    = 1'b0;
        audio_in = 1'b0;
        repeat (3) @(negedge clk);
        sb.delete();
        meas   = 1'b0;
        cand_v = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        check("midrst_silent", int'(silent), 1);
        check("midrst_note", int'(note), 0);
        tone(362, 3);
        repeat (20) @(negedge clk);
        check("note_362", int'(note), 6);
        check("octave_362", int'(octave), 0);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
